// File: rtl/note_sequence_lock.sv
// note_sequence_lock: musical combination lock fed by the note recognizer.
// It detects a programmed sequence of notes on the filtered note_vld/note_idx
// stream, holds match high for hold_ms on success, and pulses fail on a wrong
// note or (optionally) an inter-note timeout.
// Optional feature macro: NOTE_SEQ_LOCK_TIMEOUT_EN enables the LISTEN timeout.
module note_sequence_lock #(
  parameter int unsigned          clk_mhz    = 50,
  parameter int unsigned          seq_len    = 4,
  parameter logic [4*seq_len-1:0] seq        = 16'h0470,
  parameter int unsigned          timeout_ms = 2000,
  parameter int unsigned          hold_ms    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_vld,
  input  logic [3:0] note_idx,
  output logic       match,
  output logic       fail,
  output logic [3:0] progress
);

  localparam int unsigned HOLD_CYC    = clk_mhz * 1000 * hold_ms;
  localparam int unsigned TIMEOUT_CYC = clk_mhz * 1000 * timeout_ms;
  localparam int unsigned MAX_CYC     = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
  localparam int unsigned TIMER_W     = $clog2(MAX_CYC) + 1;

  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYC - 1);
`ifdef NOTE_SEQ_LOCK_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);
`endif
  localparam logic [3:0] FIRST_NOTE = seq[4*(seq_len-1) +: 4];
  localparam logic [3:0] LEN        = 4'(seq_len);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LISTEN,
    S_MATCH
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         progress_q, progress_d;
  logic               match_q, match_d;
  logic               fail_q, fail_d;
  logic               fail_req;
  logic               prev_vld_q;
  logic [3:0]         prev_idx_q;

  logic               ev;
  logic               in_range;
  logic               first_hit;
  logic [3:0]         exp_note;

  // New-note event: a rising note_vld or a change of note while valid.
  always_comb begin
    ev        = note_vld & (~prev_vld_q | (note_idx != prev_idx_q));
    in_range  = note_idx < 4'd12;
    first_hit = in_range & (note_idx == FIRST_NOTE);
  end

  // Select the note expected at the current progress position.
  always_comb begin
    exp_note = '0;
    for (int unsigned i = 0; i < seq_len; i++) begin
      if (progress_q == 4'(i)) exp_note = seq[4*(seq_len-1-i) +: 4];
    end
  end

  // Next-state, timer, progress and output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    progress_d = progress_q;
    fail_req   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev && first_hit) begin
          timer_d = '0;
          if (seq_len == 1) begin
            state_d    = S_MATCH;
            progress_d = LEN;
          end else begin
            state_d    = S_LISTEN;
            progress_d = 4'd1;
          end
        end
      end
      S_LISTEN: begin
        if (ev) begin
          timer_d = '0;
          if (in_range && (note_idx == exp_note)) begin
            progress_d = progress_q + 4'd1;
            if ((progress_q + 4'd1) == LEN) state_d = S_MATCH;
          end else begin
            fail_req = 1'b1;
            if (first_hit) begin
              progress_d = 4'd1;
            end else begin
              progress_d = '0;
              state_d    = S_IDLE;
            end
          end
        end
`ifdef NOTE_SEQ_LOCK_TIMEOUT_EN
        else if (timer_q == TIMEOUT_LAST) begin
          fail_req   = 1'b1;
          progress_d = '0;
          timer_d    = '0;
          state_d    = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      S_MATCH: begin
        if (timer_q == HOLD_LAST) begin
          state_d    = S_IDLE;
          progress_d = '0;
          timer_d    = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        progress_d = '0;
        timer_d    = '0;
      end
    endcase
    // A wrong note right after a fail still moves the FSM but does not
    // re-pulse fail, so fail is never high on back-to-back cycles.
    fail_d  = fail_req & ~fail_q;
    match_d = (state_d == S_MATCH);
  end

  // State, timer, registered outputs and note history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      progress_q <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      prev_vld_q <= 1'b0;
      prev_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      progress_q <= progress_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      prev_vld_q <= note_vld;
      prev_idx_q <= note_idx;
    end
  end

  assign match    = match_q;
  assign fail     = fail_q;
  assign progress = progress_q;

endmodule

// File: tb/tb_note_sequence_lock.sv
// Self-checking bench for note_sequence_lock (clk_mhz=1, 1000-cycle timeout
// and hold, seq 0,4,7,0). Expectations follow NOTE_SEQ_LOCK_TIMEOUT_EN.
module tb_note_sequence_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic       note_vld;
  logic [3:0] note_idx;
  logic       match;
  logic       fail;
  logic [3:0] progress;

  always #5 clk = ~clk;

  note_sequence_lock #(
    .clk_mhz   (1),
    .seq_len   (4),
    .seq       (16'h0470),
    .timeout_ms(1),
    .hold_ms   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .note_vld(note_vld),
    .note_idx(note_idx),
    .match   (match),
    .fail    (fail),
    .progress(progress)
  );

  localparam int CYC = 1000;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  string       cur_tag  = "init";
  logic [5:0]  exp_q[$];

  int          seq_notes[4] = '{0, 4, 7, 0};
  int          m_state = 0;   // 0 idle, 1 listen, 2 match
  int          m_prog  = 0;
  int          m_tmr   = 0;
  bit          m_match = 0;
  bit          m_fail  = 0;
  bit          m_pvld  = 0;
  logic [3:0]  m_pidx  = '0;
  int          match_cycles = 0;
  int          fail_pulses  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Behavioural reference of the lock, advanced once per clock edge.
  task automatic model_step(input bit r, input bit v, input logic [3:0] ix);
    bit ev;
    bit want_fail;
    want_fail = 1'b0;
    ev = v && (!m_pvld || ix != m_pidx);
    if (r) begin
      m_state = 0; m_prog = 0; m_tmr = 0; m_pvld = 0; m_pidx = '0;
      m_fail = 0; m_match = 0;
      return;
    end
    m_pvld = v;
    m_pidx = ix;
    case (m_state)
      0: if (ev && ix == seq_notes[0]) begin
           m_prog = 1; m_tmr = 0; m_state = 1;
         end
      1: begin
        if (ev) begin
          m_tmr = 0;
          if (ix == seq_notes[m_prog]) begin
            m_prog++;
            if (m_prog == 4) m_state = 2;
          end else begin
            want_fail = 1'b1;
            if (ix == seq_notes[0]) m_prog = 1;
            else begin m_prog = 0; m_state = 0; end
          end
        end else begin
`ifdef NOTE_SEQ_LOCK_TIMEOUT_EN
          if (m_tmr == CYC - 1) begin
            want_fail = 1'b1; m_prog = 0; m_tmr = 0; m_state = 0;
          end else m_tmr++;
`endif
        end
      end
      default: begin
        if (m_tmr == CYC - 1) begin
          m_state = 0; m_prog = 0; m_tmr = 0;
        end else m_tmr++;
      end
    endcase
    m_fail  = want_fail && !m_fail;
    m_match = (m_state == 2);
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] ix);
    logic [5:0] want;
    rst      = r;
    note_vld = v;
    note_idx = ix;
    model_step(r, v, ix);
    exp_q.push_back({m_match, m_fail, 4'(m_prog)});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check_eq(cur_tag, {26'd0, match, fail, progress}, {26'd0, want});
    if (match) match_cycles++;
    if (fail)  fail_pulses++;
  endtask

  task automatic press(input logic [3:0] ix, input int on_c, input int off_c);
    for (int i = 0; i < on_c; i++)  step(1'b0, 1'b1, ix);
    for (int i = 0; i < off_c; i++) step(1'b0, 1'b0, ix);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    cur_tag = "reset";
    do_reset();
    check_eq("reset_outputs", {match, fail, progress}, 6'd0);

    // Full sequence, match hold.
    cur_tag = "t1_seq";
    match_cycles = 0;
    press(4'd0, 5, 2);
    press(4'd4, 5, 2);
    press(4'd7, 5, 2);
    check_eq("t1_prog3", progress, 3);
    step(1'b0, 1'b1, 4'd0);
    check_eq("t1_match_edge", {match, progress}, {1'b1, 4'd4});
    press(4'd0, 4, 2);
    idle(CYC);
    check_eq("t1_match_len", match_cycles, CYC);
    check_eq("t1_after_hold", {match, progress}, 5'd0);

    // Wrong notes.
    cur_tag = "t2_wrong";
    do_reset();
    fail_pulses = 0;
    press(4'd0, 5, 2);
    press(4'd4, 5, 2);
    press(4'd9, 5, 2);
    check_eq("t2_fail_9", {fail_pulses[3:0], progress}, {4'd1, 4'd0});
    press(4'd0, 5, 2);
    press(4'd4, 5, 2);
    press(4'd0, 5, 2);
    check_eq("t2_fail_restart", {fail_pulses[3:0], progress}, {4'd2, 4'd1});

    // Inter-note timeout.
    cur_tag = "t3_timeout";
    do_reset();
    fail_pulses = 0;
    press(4'd0, 1, 0);
    idle(CYC - 1);
    check_eq("t3_before_timeout", {fail_pulses[3:0], progress}, {4'd0, 4'd1});
    idle(1);
`ifdef NOTE_SEQ_LOCK_TIMEOUT_EN
    check_eq("t3_timeout_edge", {fail, progress}, {1'b1, 4'd0});
`else
    check_eq("t3_no_timeout", {fail, progress}, {1'b0, 4'd1});
    press(4'd4, 5, 2);
    press(4'd7, 5, 2);
    press(4'd0, 5, 2);
    check_eq("t3_late_match", {match, progress}, {1'b1, 4'd4});
`endif
    idle(CYC);

    // Note change without vld drop.
    cur_tag = "t4_change";
    do_reset();
    fail_pulses = 0;
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 4'd4);
    check_eq("t4_prog2", {fail_pulses[3:0], progress}, {4'd0, 4'd2});
    idle(2);

    // Reset in MATCH and in LISTEN.
    cur_tag = "t5_rst";
    do_reset();
    press(4'd0, 5, 2);
    press(4'd4, 5, 2);
    press(4'd7, 5, 2);
    press(4'd0, 5, 2);
    check_eq("t5_in_match", match, 1);
    step(1'b1, 1'b0, 4'd0);
    check_eq("t5_rst_match", {match, fail, progress}, 6'd0);
    step(1'b0, 1'b0, 4'd0);
    press(4'd0, 5, 2);
    press(4'd4, 5, 2);
    press(4'd7, 5, 2);
    check_eq("t5_prog3", progress, 3);
    step(1'b1, 1'b0, 4'd0);
    check_eq("t5_rst_listen", {match, fail, progress}, 6'd0);
    step(1'b0, 1'b0, 4'd0);

    // Note on the exact timeout cycle, then out-of-range index.
    cur_tag = "t6_boundary";
    do_reset();
    step(1'b0, 1'b1, 4'd0);
    idle(CYC - 1);
    step(1'b0, 1'b1, 4'd4);
    check_eq("t6_on_timeout", {fail, progress}, {1'b0, 4'd2});
    step(1'b0, 1'b1, 4'd13);
    check_eq("t6_idx13", {fail, progress}, {1'b1, 4'd0});
    idle(2);

    // Back-to-back wrong notes give a single fail pulse.
    cur_tag = "t7_b2b";
    do_reset();
    press(4'd0, 2, 1);
    press(4'd4, 2, 1);
    step(1'b0, 1'b1, 4'd0);
    check_eq("t7_first_fail", {fail, progress}, {1'b1, 4'd1});
    step(1'b0, 1'b1, 4'd9);
    check_eq("t7_no_second", {fail, progress}, {1'b0, 4'd0});
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
